// File: rtl/operand_mux_pipe.sv
// N-input operand select with a registered valid/ready output stage.
// Define OPERAND_MUX_SKID_EN to add a 1-entry skid buffer (registered in_ready).
module operand_mux_pipe #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_IN      = 3,
  parameter int          SEL_W       = $clog2(NUM_IN),
  parameter logic [31:0] DEFAULT_VAL = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [15:0]             err_count
);

  logic [WIDTH-1:0] sel_val;
  logic             in_range;
  logic             accept;

  always_comb begin
    sel_val = WIDTH'(DEFAULT_VAL);
    for (int k = 0; k < NUM_IN; k++) begin
      if (32'(sel) == k) sel_val = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign in_range = 32'(sel) < NUM_IN;
  assign accept   = in_valid && in_ready;

  // Error flag and counter track accepts only, never deliveries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err   <= 1'b0;
      err_count <= 16'h0000;
    end else begin
      sel_err <= accept && !in_range;
      if (accept && !in_range && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

`ifdef OPERAND_MUX_SKID_EN
  typedef enum logic {EMPTY, FULL} skid_state_t;

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic [WIDTH-1:0] skid_data;
  logic             load_out;
  logic             load_skid;
  logic             pop_skid;
  logic             clr_valid;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    clr_valid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          if (out_valid && !out_ready) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else begin
            load_out = 1'b1;
          end
        end else if (out_ready) begin
          clr_valid = 1'b1;
        end
      end
      FULL: begin
        if (out_ready) begin
          pop_skid  = 1'b1;
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  assign in_ready = (state == EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      skid_data <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_skid) skid_data <= sel_val;
      if (load_out) begin
        out_data  <= sel_val;
        out_valid <= 1'b1;
      end else if (pop_skid) begin
        out_data <= skid_data;
      end else if (clr_valid) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= sel_val;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed bench for operand_mux_pipe with a queue scoreboard.
// Works in both builds (OPERAND_MUX_SKID_EN defined or not).
module tb_operand_mux_pipe;

`ifdef OPERAND_MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] DEF = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;
  logic [15:0] err_count;

  operand_mux_pipe #(
    .WIDTH(32),
    .NUM_IN(3),
    .DEFAULT_VAL(DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .sel(sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err(sel_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];
  logic [15:0] exp_cnt = 16'h0;
  logic        exp_err = 1'b0;
  logic [31:0] src[3] = '{32'h11, 32'h22, 32'h33};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_val(input logic [1:0] s);
    return (s < 2'd3) ? src[s] : DEF;
  endfunction

  // Check current outputs, predict the coming edge, then advance one cycle.
  task automatic tick(output bit acc);
    logic exp_rdy;
    bit   dlv;
    #1;
    exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    chk("err_count", 32'(err_count), 32'(exp_cnt));
    chk("sel_err", 32'(sel_err), 32'(exp_err));
    acc = in_valid && exp_rdy;
    dlv = (q.size() != 0) && out_ready;
    if (dlv) void'(q.pop_front());
    if (acc) begin
      q.push_back(model_val(sel));
      exp_err = (sel == 2'd3);
      if (sel == 2'd3 && exp_cnt != 16'hFFFF) exp_cnt++;
    end else begin
      exp_err = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic r);
    bit acc;
    in_valid  = v;
    sel       = s;
    out_ready = r;
    tick(acc);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    chk({tag, "_err_count"}, 32'(err_count), 32'h0);
    chk({tag, "_sel_err"}, 32'(sel_err), 32'h0);
  endtask

  initial begin
    bit acc;
    int beat;
    in_data   = {src[2], src[1], src[0]};
    rst       = 1'b1;
    in_valid  = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;

    // reset and basic path
    #1;
    reset_checks("rst_during");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    reset_checks("rst_after");
    @(posedge clk);
    #1;
    drive(1'b1, 2'd2, 1'b1);
    chk("basic_data", out_data, 32'h33);
    chk("basic_valid", 32'(out_valid), 32'h1);
    drive(1'b0, 2'd0, 1'b1);

    // out-of-range select
    drive(1'b1, 2'd3, 1'b1);
    chk("oor_data", out_data, DEF);
    chk("oor_err_hi", 32'(sel_err), 32'h1);
    chk("oor_cnt", 32'(err_count), 32'h1);
    drive(1'b0, 2'd0, 1'b1);
    chk("oor_err_lo", 32'(sel_err), 32'h0);
    drive(1'b0, 2'd0, 1'b1);

    // back-pressure: sel 0,1,2 streamed, out_ready low in cycles 2..4
    beat = 0;
    for (int c = 1; c <= 12; c++) begin
      in_valid  = (beat < 3);
      sel       = 2'(beat);
      out_ready = !(c >= 2 && c <= 4);
      tick(acc);
      if (acc) beat++;
    end
    chk("bp_all_accepted", 32'(beat), 32'd3);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // counter saturation
    for (int i = 0; i < 65540; i++) drive(1'b1, 2'd3, 1'b1);
    chk("sat_cnt", 32'(err_count), 32'h0000_FFFF);
    chk("sat_err_pulse", 32'(sel_err), 32'h1);
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);

    // reset mid-stream with output valid (and skid full in the skid build)
    drive(1'b1, 2'd0, 1'b1);
    drive(1'b1, 2'd1, 1'b0);
    in_valid = 1'b0;
    drive(1'b0, 2'd2, 1'b0);
    chk("mid_valid_before", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("mid_rst");
    q.delete();
    exp_cnt = 16'h0;
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 2'd1, 1'b1);
    chk("post_rst_first", out_data, 32'h22);
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_mux_pipe.md
# operand_mux_pipe

Parametrised N-input operand select stage with a registered, valid/ready-handshaked output, for the pipelined core's operand-forwarding paths. It picks one of `NUM_IN` WIDTH-bit sources per beat and forwards the result one cycle later. Out-of-range selects produce a programmable default value and are flagged and counted. An optional skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `WIDTH`, 32, data width of each source and of the output
- `NUM_IN`, 3, number of sources; legal range 2..16
- `SEL_W`, `$clog2(NUM_IN)`, select width; derived, never overridden
- `DEFAULT_VAL`, 32'h0000_0000, output value for an out-of-range select; truncated to `WIDTH`
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  NUM_IN*WIDTH  packed sources; source k is bits [k*WIDTH +: WIDTH]
- `sel`  in  SEL_W  source index, sampled with the beat
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat
- `out_data`  out  WIDTH  selected value
- `out_valid`  out  1  `out_data` holds a beat
- `out_ready`  in  1  downstream accepts the beat
- `sel_err`  out  1  one-cycle pulse: an out-of-range select was accepted
- `err_count`  out  16  saturating count of out-of-range selects

## Operation
- A beat is accepted on a rising edge where `in_valid && in_ready`. A beat is delivered on a rising edge where `out_valid && out_ready`.
- Selected value = source `sel` if `sel < NUM_IN`, else `DEFAULT_VAL`. `sel` values from `NUM_IN` to 2^SEL_W-1 are out of range.
- Accepting an out-of-range beat has three effects:
  - the beat still flows downstream, carrying `DEFAULT_VAL`;
  - `sel_err` is high for the one cycle after the accept edge;
  - `err_count` increments on the accept edge and saturates at 16'hFFFF.
- Beats are delivered strictly in acceptance order. None is dropped or duplicated.
- `out_data` is held stable while `out_valid && !out_ready`.
- Output register behaviour without skid:
  - `in_ready = !out_valid || out_ready`, combinational.
  - On accept, the output register loads the selected value and `out_valid` is set.
  - On a delivery with no accept, `out_valid` clears.
- Skid-buffer states (with skid only):
  - EMPTY: skid entry unused; `in_ready` = 1.
  - FULL: skid entry holds one beat; `in_ready` = 0.
  - EMPTY→FULL: a beat is accepted while `out_valid && !out_ready`; the beat goes into the skid entry.
  - FULL→EMPTY: `out_ready` is high; the skid beat moves into the output register.
- Reset values, applied asynchronously while `rst` is high:
  - `out_valid` = 0, `out_data` = 0
  - `sel_err` = 0, `err_count` = 0
  - skid state EMPTY
  - `in_ready` = 1
- Reset mid-operation discards any beat in the output register or skid entry.

## Timing
- Latency: 1 cycle. A beat accepted at edge N appears with `out_valid` = 1 after edge N.
- Throughput: 1 beat per cycle while `out_ready` is held high, in both configurations.
- Without skid, `out_ready` → `in_ready` is a combinational path. With skid, `in_ready` is a flop output.
- With skid, `in_ready` falls one cycle after the stall is observed. The beat accepted in that cycle lands in the skid entry.
- Simultaneous accept and deliver with the output register full and skid EMPTY: the output register takes the new beat and the skid stays EMPTY.
- Skid FULL with `out_ready` = 1: the skid beat moves to the output and `in_ready` = 1 in the next cycle. No accept is possible in that cycle.
- `sel_err` and `err_count` update on the accept edge only, never on delivery.

## Configuration
- `OPERAND_MUX_SKID_EN` defined:
  - 1-entry skid buffer compiled in.
  - `in_ready` is registered.
  - Full throughput under back-pressure.
- `OPERAND_MUX_SKID_EN` not defined:
  - No skid state.
  - `in_ready = !out_valid || out_ready`.
  - Same data, ordering, error and reset behaviour.
- Both builds must pass the full test plan.

## Test plan
- Reset and basic path: `rst` pulse, NUM_IN=3, sources {32'h11, 32'h22, 32'h33}, `out_ready` = 1, sel=2 for one beat.
  - During and after reset: `out_valid` = 0, `in_ready` = 1, `err_count` = 0.
  - One cycle after the accept: `out_data` = 32'h33, `out_valid` = 1.
- Out-of-range select: sel=3 with DEFAULT_VAL=32'hDEAD_BEEF.
  - `out_data` = 32'hDEAD_BEEF.
  - `sel_err` high for exactly one cycle.
  - `err_count` = 1.
- Back-pressure, skid build: stream sel=0,1,2 on consecutive cycles, `out_ready` = 0 for cycles 2–4.
  - `in_ready` drops after one beat lands in the skid entry.
  - Outputs are 32'h11, 32'h22, 32'h33 in order; nothing lost.
- Back-pressure, non-skid build: same stimulus.
  - `in_ready` = 0 in the same cycle `out_ready` = 0 with `out_valid` = 1.
  - Same output order.
- Counter saturation: force 65 540 out-of-range accepts.
  - `err_count` holds at 16'hFFFF.
  - `sel_err` still pulses on each error.
- Reset mid-stream: assert `rst` with the skid FULL and the output register valid.
  - `out_valid` = 0 immediately.
  - First beat after reset is the next newly accepted one.
